// File: rtl/poly_addsub_stream.sv
// poly_addsub_stream
//   Streaming modular add/subtract over polynomial coefficients, LANES
//   coefficients per beat, two-stage pipeline with ready/valid backpressure.
//   Inputs are lazily reduced ([0, 2Q-1]); outputs are fully reduced ([0, Q-1]).
//
// Ports
//   clk, rst_n        : clock (rising edge), async active-low reset
//   in_valid/in_ready : input handshake; op (0 add, 1 a-b) sampled with the beat
//   dia, dib          : operands, lane k at [k*DW +: DW]
//   out_valid/out_ready, dout, out_last : result stream, out_last on the final
//                       beat of each N-coefficient polynomial
//   err               : sticky input-range error
//
// Build option
//   POLY_ADDSUB_RANGE_CHK_EN : when defined, err latches if any lane of dia/dib
//                              is >= 2Q on an accepted beat; otherwise err is 0.

// One coefficient lane: stage 1 holds the unreduced sum, stage 2 the reduced result.
module poly_addsub_lane #(
   parameter int DW = 16,
   parameter int Q  = 12289
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_en,
   input  logic          i_op,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   output logic [DW-1:0] o_d
);
   localparam int TW = DW + 2;
   localparam logic [TW-1:0] Q1 = TW'(Q);
   localparam logic [TW-1:0] Q2 = TW'(2 * Q);
   localparam logic [TW-1:0] Q3 = TW'(3 * Q);

   logic [TW-1:0] w_t, w_r, r_t;
   logic [DW-1:0] r_dout;

   // Subtract is biased by 2Q so t never goes negative for legal inputs;
   // the op is fully absorbed into t, so stage 2 needs only t.
   always_comb begin
      w_t = '0;
      if (i_op) w_t = {2'b00, i_a} - {2'b00, i_b} + Q2;
      else      w_t = {2'b00, i_a} + {2'b00, i_b};
   end

   // t < 4Q, so at most one of the three subtractions is needed.
   always_comb begin
      w_r = r_t;
      if      (r_t >= Q3) w_r = r_t - Q3;
      else if (r_t >= Q2) w_r = r_t - Q2;
      else if (r_t >= Q1) w_r = r_t - Q1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t    <= '0;
         r_dout <= '0;
      end else if (i_en) begin
         r_t    <= w_t;
         r_dout <= DW'(w_r);
      end
   end

   assign o_d = r_dout;
endmodule

module poly_addsub_stream #(
   parameter int DW    = 16,
   parameter int Q     = 12289,
   parameter int LANES = 1,
   parameter int N     = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                op,
   input  logic [LANES*DW-1:0] dia,
   input  logic [LANES*DW-1:0] dib,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES*DW-1:0] dout,
   output logic                out_last,
   output logic                err
);
   localparam int STAGES = 2;
   localparam int BEATS  = N / LANES;
   localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   logic [LANES-1:0][DW-1:0] w_a, w_b, w_d;
   logic [STAGES:1]          r_vld_pipe;
   logic                     r_last;
   logic [CW-1:0]            r_cnt, w_cnt_nxt;
   logic                     w_adv, w_fire, w_out_fire;

   assign w_a = dia;
   assign w_b = dib;

   // Whole pipeline moves together; stalls only when the output is held.
   assign w_adv      = !r_vld_pipe[STAGES] || out_ready;
   assign in_ready   = rst_n && w_adv;
   assign w_fire     = in_valid && in_ready;
   assign w_out_fire = r_vld_pipe[STAGES] && out_ready;

   // Counter value seen by the beat about to enter stage 2, accounting for
   // the handshake of the beat leaving it on the same edge.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_out_fire) w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_last     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_fire};
            r_last     <= r_vld_pipe[1] && (w_cnt_nxt == LAST);
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      poly_addsub_lane #(.DW(DW), .Q(Q)) u_lane (
         .clk  (clk),
         .rst_n(rst_n),
         .i_en (w_adv),
         .i_op (op),
         .i_a  (w_a[k]),
         .i_b  (w_b[k]),
         .o_d  (w_d[k])
      );
   end

   assign dout      = w_d;
   assign out_valid = r_vld_pipe[STAGES];
   assign out_last  = r_last;

`ifdef POLY_ADDSUB_RANGE_CHK_EN
   localparam logic [DW+1:0] Q2C = (DW+2)'(2 * Q);
   logic [LANES-1:0] w_oor;
   logic             r_err;

   for (genvar k = 0; k < LANES; k++) begin : g_chk
      assign w_oor[k] = ({2'b00, w_a[k]} >= Q2C) || ({2'b00, w_b[k]} >= Q2C);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_err <= 1'b0;
      else if (w_fire && |w_oor)   r_err <= 1'b1;
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_poly_addsub_stream.sv
module tb_poly_addsub_stream;
   localparam int DW = 16, Q = 12289, LANES = 4, N = 1024, BEATS = N / LANES;
   localparam int W = LANES * DW;
`ifdef POLY_ADDSUB_RANGE_CHK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op = 1'b0, out_ready = 1'b1;
   logic         in_ready, out_valid, out_last, err;
   logic [W-1:0] dia = '0, dib = '0, dout;

   poly_addsub_stream #(.DW(DW), .Q(Q), .LANES(LANES), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .dia(dia), .dib(dib), .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .out_last(out_last), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         last;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   int           n_chk = 0, n_fail = 0, cyc = 0, beat_idx = 0;
   bit           rnd_rdy = 0, chk_lat = 0, hold_v = 0;
   logic [W-1:0] hold_d;
   logic         hold_l;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] modref(input int a, input int b, input bit o);
      int t;
      t = o ? (a - b + 2 * Q) : (a + b);
      return DW'(t % Q);
   endfunction

   // Entry and exit at 1 time unit after a rising edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit o,
                       input logic [W-1:0] e);
      int w = 0;
      dia = a; dib = b; op = o; in_valid = 1'b1;
      do begin
         @(negedge clk);
         w++;
      end while (!in_ready && w < 2000);
      if (!in_ready) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", w);
      end else begin
         sb.push_back('{e, (beat_idx == BEATS - 1), cyc});
         beat_idx = (beat_idx + 1) % BEATS;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [W-1:0] a, b, e;
      bit o;
      int av, bv;
      o = 1'($urandom_range(0, 1));
      for (int k = 0; k < LANES; k++) begin
         av = $urandom_range(0, 2 * Q - 1);
         bv = $urandom_range(0, 2 * Q - 1);
         a[k*DW +: DW] = DW'(av);
         b[k*DW +: DW] = DW'(bv);
         e[k*DW +: DW] = modref(av, bv, o);
      end
      send(a, b, o, e);
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 4000) begin
         @(posedge clk); #1;
         w++;
      end
      if (sb.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: %0d beats still outstanding", sb.size());
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      out_ready = rnd_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
   end

   // Monitor / scoreboard
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (hold_v) chk("stall_hold", {out_valid, out_last, dout}, {1'b1, hold_l, hold_d});
      hold_v = rst_n && out_valid && !out_ready;
      hold_d = dout;
      hold_l = out_last;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL extra_beat: got dout %0h with no beat outstanding", dout);
         end else begin
            e = sb.pop_front();
            chk("dout_last", {out_last, dout}, {e.last, e.d});
            if (chk_lat) chk("latency", cyc - e.cyc, 2);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_dout",      dout,      0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_err",       err,       0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_release", in_ready, 1);

      // Directed vectors, op alternating beat to beat, latency checked.
      chk_lat = 1;
      send({16'd1, 16'd0, 16'd24577, 16'd12288}, {16'd2, 16'd0, 16'd24577, 16'd12288}, 1'b0,
           {16'd3, 16'd0, 16'd12287, 16'd12287});
      send({16'd7, 16'd24577, 16'd5, 16'd0}, {16'd7, 16'd0, 16'd24577, 16'd1}, 1'b1,
           {16'd0, 16'd12288, 16'd6, 16'd12288});
      send({16'd3, 16'd24000, 16'd12289, 16'd100}, {16'd4, 16'd24000, 16'd0, 16'd200}, 1'b0,
           {16'd7, 16'd11133, 16'd0, 16'd300});
      drain();
      chk_lat = 0;

      // Random backpressure with input gaps.
      rnd_rdy = 1;
      for (int i = 0; i < 1000; i++) begin
         send_rand();
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain();
      rnd_rdy = 0;

      // Continuous flow across several polynomial wraps.
      for (int i = 0; i < 600; i++) send_rand();
      drain();

      // Reset mid-polynomial with beats in flight.
      for (int i = 0; i < 100; i++) send_rand();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_dout",      dout,      0);
      chk("midrst_out_last",  out_last,  0);
      chk("midrst_in_ready",  in_ready,  0);
      chk("midrst_err",       err,       0);
      sb.delete();
      beat_idx = 0;
      hold_v = 0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_midrst", in_ready, 1);
      for (int i = 0; i < BEATS; i++) send_rand();
      drain();

      // Range check: lane 2 of dia out of range, data still flows.
      chk("err_before_inject", err, 0);
      send({16'd10, 16'd24578, 16'd20, 16'd30}, '0, 1'b0, {16'd10, 16'd0, 16'd20, 16'd30});
      chk("err_after_inject", err, EXP_ERR);
      repeat (5) @(posedge clk);
      #1;
      send({16'd1, 16'd2, 16'd3, 16'd4}, {16'd1, 16'd1, 16'd1, 16'd1}, 1'b1,
           {16'd0, 16'd1, 16'd2, 16'd3});
      drain();
      chk("err_sticky", err, EXP_ERR);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
